// File: rtl/ds_upscaler_2x.sv
// ds_upscaler_2x: 2x nearest-neighbour upscaler using a ping-pong line buffer; each line is replayed twice with pixel doubling.
// Define UPSCALE_INTERP_EN to average neighbouring pixels on odd output positions instead of replicating them.
module ds_upscaler_2x #(
  parameter int WIDTH   = 10,
  parameter int HACT_IN = 320,
  parameter int HGAP    = 16,
  parameter int HSW     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_r_data,
  input  logic [WIDTH-1:0] i_g_data,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [WIDTH-1:0] o_r_data,
  output logic [WIDTH-1:0] o_g_data,
  output logic [WIDTH-1:0] o_b_data,
  output logic             o_ovf
);
  localparam int PW = $clog2(2*HACT_IN+1);
  localparam int AW = $clog2(HACT_IN);
  localparam int GW = $clog2(HGAP+1);
  localparam int CW = PW > GW ? PW : GW;
  localparam int DW = 3*WIDTH;
  typedef enum logic [2:0] {IDLE, GAP0, ACT0, GAP1, ACT1} state_t;
  state_t state;
  logic [DW-1:0] mem [2][HACT_IN];
  logic [PW-1:0] wr_ptr, len, rd_len, len2;
  logic [CW-1:0] cnt;
  logic [AW-1:0] k;
  logic [DW-1:0] p0, pix;
  logic de_d, drop, wb, rb, hb, pending;
  logic vs_rise, de_rise, de_fall, busy, gap, act, gap_end, act_end;
  logic ovr_rise, ovr_hand, skip, wr, hand, take, do_hand;
  logic unused_hsync;
  assign unused_hsync = i_hsync;
  assign vs_rise  = i_vsync & ~o_vsync;
  assign de_rise  = i_de & ~de_d;
  assign de_fall  = ~i_de & de_d;
  assign busy     = state != IDLE;
  assign gap      = state == GAP0 || state == GAP1;
  assign act      = state == ACT0 || state == ACT1;
  assign len2     = rd_len << 1;
  assign gap_end  = cnt == CW'(HGAP-1);
  assign act_end  = cnt == CW'(len2 - PW'(1));
  // A line that starts while its target bank is still being replayed is dropped whole.
  assign ovr_rise = de_rise & (wb == rb) & busy;
  assign skip     = drop | ovr_rise | (vs_rise & de_d);
  assign wr       = i_de & ~skip & (wr_ptr < PW'(HACT_IN));
  assign hand     = de_fall & ~drop & (wr_ptr != '0);
  assign take     = pending & (state == IDLE || (state == ACT1 && act_end));
  assign ovr_hand = hand & pending & ~take;
  assign do_hand  = hand & ~ovr_hand;
  assign k        = cnt[AW:1];
  assign p0       = mem[rb][k];
`ifdef UPSCALE_INTERP_EN
  logic [DW-1:0] p1;
  logic last;
  assign p1   = mem[rb][k + AW'(1)];
  assign last = PW'(k) == rd_len - PW'(1);
  for (genvar c = 0; c < 3; c++) begin : g_avg
    assign pix[c*WIDTH +: WIDTH] = (cnt[0] & ~last)
      ? WIDTH'(({1'b0, p0[c*WIDTH +: WIDTH]} + {1'b0, p1[c*WIDTH +: WIDTH]}) >> 1)
      : p0[c*WIDTH +: WIDTH];
  end
`else
  assign pix = p0;
`endif
  always_ff @(posedge clk)
    if (wr) mem[wb][wr_ptr[AW-1:0]] <= {i_r_data, i_g_data, i_b_data};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      len      <= '0;
      rd_len   <= '0;
      de_d     <= 1'b0;
      drop     <= 1'b1;
      wb       <= 1'b0;
      rb       <= 1'b0;
      hb       <= 1'b0;
      pending  <= 1'b0;
      o_vsync  <= 1'b0;
      o_hsync  <= 1'b0;
      o_de     <= 1'b0;
      o_r_data <= '0;
      o_g_data <= '0;
      o_b_data <= '0;
      o_ovf    <= 1'b0;
    end else begin
      de_d    <= i_de;
      o_vsync <= i_vsync;
      drop    <= i_de & skip;
      wr_ptr  <= (de_fall | (vs_rise & de_d)) ? '0 : wr ? wr_ptr + 1'b1 : wr_ptr;
      if (do_hand) begin
        len <= wr_ptr;
        hb  <= wb;
        wb  <= ~wb;
      end
      pending <= do_hand | (pending & ~take);
      o_ovf   <= ~vs_rise & (o_ovf | ovr_rise | ovr_hand);
      if (take) begin
        rb     <= hb;
        rd_len <= len;
      end
      cnt <= (!busy || (gap && gap_end) || (act && act_end)) ? '0 : cnt + 1'b1;
      case (state)
        IDLE:    state <= pending ? GAP0 : IDLE;
        GAP0:    state <= gap_end ? ACT0 : GAP0;
        ACT0:    state <= act_end ? GAP1 : ACT0;
        GAP1:    state <= gap_end ? ACT1 : GAP1;
        ACT1:    state <= act_end ? (pending ? GAP0 : IDLE) : ACT1;
        default: state <= IDLE;
      endcase
      o_hsync  <= gap & (cnt < CW'(HSW));
      o_de     <= act;
      o_r_data <= act ? pix[3*WIDTH-1:2*WIDTH] : '0;
      o_g_data <= act ? pix[2*WIDTH-1:WIDTH] : '0;
      o_b_data <= act ? pix[WIDTH-1:0] : '0;
    end
endmodule

// File: tb/tb_ds_upscaler_2x.sv
// tb_ds_upscaler_2x: directed scoreboard bench for the 2x line upscaler (small geometry).
module tb_ds_upscaler_2x;
  localparam int W = 10, HI = 4, HG = 4, HS = 2;
  logic clk = 0, rstn = 0, i_vsync = 0, i_hsync = 0, i_de = 0;
  logic [W-1:0] i_r_data = '0, i_g_data = '0, i_b_data = '0;
  logic o_vsync, o_hsync, o_de, o_ovf;
  logic [W-1:0] o_r_data, o_g_data, o_b_data;
  ds_upscaler_2x #(.WIDTH(W), .HACT_IN(HI), .HGAP(HG), .HSW(HS)) dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .i_r_data(i_r_data), .i_g_data(i_g_data), .i_b_data(i_b_data),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data), .o_ovf(o_ovf));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [3*W-1:0] sb[$];
  logic [3*W-1:0] exp_px;
  int checks = 0, errors = 0, lines = 0, de_cycles = 0;
  int hs_run = 0, hs_rise = 0, first_de = -1, t_fall = 0, l0 = 0, d0 = 0;
  bit o_de_q = 0, hs_q = 0;
  function automatic logic [3*W-1:0] px(int base, int i);
    return {W'(base + 10*i), W'(base + 5 + 7*i), W'(1000 - base - 3*i)};
  endfunction
  function automatic logic [3*W-1:0] avg(logic [3*W-1:0] a, logic [3*W-1:0] b);
    logic [3*W-1:0] r;
    for (int c = 0; c < 3; c++) r[c*W +: W] = W'((int'(a[c*W +: W]) + int'(b[c*W +: W])) / 2);
    return r;
  endfunction
  task automatic chk(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic push_line(int base, int len);
    logic [3*W-1:0] e;
    for (int rep = 0; rep < 2; rep++)
      for (int x = 0; x < 2*len; x++) begin
        e = px(base, x/2);
`ifdef UPSCALE_INTERP_EN
        if (x % 2 == 1 && x/2 < len - 1) e = avg(px(base, x/2), px(base, x/2 + 1));
`endif
        sb.push_back(e);
      end
  endtask
  task automatic send_line(int n, int base, bit expect_out);
    if (expect_out) push_line(base, n > HI ? HI : n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_de = 1;
      {i_r_data, i_g_data, i_b_data} = px(base, i);
    end
    @(negedge clk);
    i_de = 0;
    {i_r_data, i_g_data, i_b_data} = '0;
    t_fall = cyc + 1;
  endtask
  task automatic drain(string tag);
    int n = 0;
    while ((sb.size() != 0 || o_de) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask
  always @(negedge clk)
    if (!rstn) begin
      o_de_q = 0;
      hs_q = 0;
    end else begin
      if (o_hsync && !hs_q) begin
        hs_rise = cyc;
        hs_run = 1;
      end else if (o_hsync) hs_run++;
      if (!o_hsync && hs_q) begin
        checks++;
        assert (hs_run === HS) else begin
          errors++;
          $error("FAIL hsync_width observed %0d expected %0d", hs_run, HS);
        end
      end
      if (o_de) begin
        if (!o_de_q) begin
          lines++;
          if (first_de < 0) first_de = cyc;
          checks++;
          assert (cyc - hs_rise === HG) else begin
            errors++;
            $error("FAIL gap_len observed %0d expected %0d", cyc - hs_rise, HG);
          end
        end
        de_cycles++;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_de observed pixel %h expected none", {o_r_data, o_g_data, o_b_data});
        end
        if (sb.size() != 0) begin
          exp_px = sb.pop_front();
          checks++;
          assert ({o_r_data, o_g_data, o_b_data} === exp_px) else begin
            errors++;
            $error("FAIL pixel observed %h expected %h", {o_r_data, o_g_data, o_b_data}, exp_px);
          end
        end
      end else begin
        checks++;
        assert ({o_r_data, o_g_data, o_b_data} === '0) else begin
          errors++;
          $error("FAIL blank_zero observed %h expected 0", {o_r_data, o_g_data, o_b_data});
        end
      end
      o_de_q = o_de;
      hs_q = o_hsync;
    end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctl", int'({o_vsync, o_hsync, o_de, o_ovf}), 0);
    chk("reset_rgb", int'({o_r_data, o_g_data, o_b_data}), 0);
    rstn = 1;
    repeat (2) @(negedge clk);
    l0 = lines; d0 = de_cycles; first_de = -1;
    send_line(4, 10, 1);
    repeat (40) @(negedge clk);
    chk("single_lines", lines - l0, 2);
    chk("single_de", de_cycles - d0, 16);
    chk("latency", first_de - t_fall, HG + 2);
    chk("single_sb", sb.size(), 0);
    l0 = lines;
    send_line(4, 50, 1);
    repeat (19) @(negedge clk);
    send_line(4, 100, 1);
    repeat (19) @(negedge clk);
    send_line(4, 150, 1);
    drain("b2b_sb");
    chk("b2b_lines", lines - l0, 6);
    chk("b2b_ovf", o_ovf, 0);
    l0 = lines;
    send_line(4, 200, 1);
    repeat (1) @(negedge clk);
    send_line(4, 300, 1);
    repeat (1) @(negedge clk);
    send_line(4, 400, 0);
    chk("ovr_flag", o_ovf, 1);
    drain("ovr_sb");
    chk("ovr_lines", lines - l0, 4);
    chk("ovr_sticky", o_ovf, 1);
    @(negedge clk);
    i_vsync = 1;
    @(negedge clk);
    chk("vsync_dly", o_vsync, 1);
    chk("ovr_clear", o_ovf, 0);
    i_vsync = 0;
    @(negedge clk);
    chk("vsync_low", o_vsync, 0);
    l0 = lines; d0 = de_cycles;
    send_line(6, 500, 1);
    drain("trunc_sb");
    chk("trunc_de", de_cycles - d0, 16);
    chk("trunc_lines", lines - l0, 2);
    l0 = lines;
    @(negedge clk); i_de = 1; {i_r_data, i_g_data, i_b_data} = px(90, 0);
    @(negedge clk); {i_r_data, i_g_data, i_b_data} = px(90, 1);
    @(negedge clk); i_vsync = 1; {i_r_data, i_g_data, i_b_data} = px(90, 2);
    @(negedge clk); {i_r_data, i_g_data, i_b_data} = px(90, 3);
    @(negedge clk); i_de = 0; {i_r_data, i_g_data, i_b_data} = '0;
    @(negedge clk); i_vsync = 0;
    repeat (40) @(negedge clk);
    chk("partial_lines", lines - l0, 0);
    l0 = lines; d0 = de_cycles;
    send_line(3, 60, 1);
    drain("short_sb");
    chk("short_de", de_cycles - d0, 12);
    send_line(4, 70, 1);
    begin
      int n = 0;
      while (!o_de && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_de_seen", o_de, 1);
    rstn = 0;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_ctl", int'({o_vsync, o_hsync, o_de, o_ovf}), 0);
    chk("rst_mid_rgb", int'({o_r_data, o_g_data, o_b_data}), 0);
    rstn = 1;
    l0 = lines;
    repeat (40) @(negedge clk);
    chk("rst_no_de", lines - l0, 0);
    send_line(4, 80, 1);
    drain("post_rst_sb");
    chk("post_rst_lines", lines - l0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
